truck_move: RTL
===============

# truck_move

Per-frame motion controller for the truck sprite. It produces the registered top-left screen coordinate of the truck. That coordinate feeds the truck square-object stage, which derives offsetX/offsetY/InsideRectangle for the truck bitmap. Once per video frame the block advances the truck leftward at a selectable fixed-point speed. When the truck leaves the screen it respawns on a pseudo-random lane. On a collision report it freezes for a fixed number of frames.

## Interface
Parameters:
- INITIAL_X, 640: respawn / reset X (pixels).
- LANE_BASE_Y, 160: Y of lane 0 (pixels).
- LANE_PITCH, 64: Y distance between lanes (pixels).
- X_MIN, -32: truck is off-screen when X falls below this value.
- FP_SHIFT, 6: fixed-point fraction bits (multiplier 64).
- HIT_FRAMES, 32: frames frozen after a hit.

Ports. One clock; reset is asynchronous and active-high.
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- startOfFrame, in, 1: single-cycle pulse, once per frame.
- enable, in, 1: game running; low pauses the block.
- collision, in, 1: truck pixel overlaps the player (may be asserted for many cycles).
- speedLevel, in, 2: 0..3 selects 1, 1.5, 2 or 3 px/frame (64/96/128/192 fp units).
- topLeftX, out, 11 signed: truck X in pixels.
- topLeftY, out, 11 signed: truck Y in pixels.
- hitPulse, out, 1: one-cycle pulse when a hit is accepted.
- wrapPulse, out, 1: one-cycle pulse on respawn.
- moving, out, 1: high in DRIVE.

## Operation
- Internal state:
  - posX: 18-bit signed fixed point.
  - lane: 2 bits.
  - lfsr: 4 bits, polynomial x^4+x^3+1, seed 4'b1001, steps every startOfFrame.
  - hitCnt: 6 bits.
  - hitSticky: 1 bit.
- Output mapping: topLeftX = posX >>> FP_SHIFT (arithmetic shift, floor). topLeftY = LANE_BASE_Y + lane*LANE_PITCH.
- hitSticky is set by collision in any cycle while in DRIVE. It is cleared on each startOfFrame after being sampled.
- State machine; all transitions are evaluated only on startOfFrame cycles:
  - IDLE: enable=1 -> DRIVE.
  - DRIVE:
    - enable=0 -> IDLE.
    - else if (hitSticky | collision) -> HIT. Load hitCnt=HIT_FRAMES-1, pulse hitPulse, posX unchanged.
    - else posX -= speed. If the result is < X_MIN<<FP_SHIFT: posX = INITIAL_X<<FP_SHIFT, lane = lfsr[1:0] (value before this step), pulse wrapPulse.
  - HIT:
    - enable=0 -> IDLE; hitCnt is cleared.
    - else if hitCnt==0 -> DRIVE.
    - else hitCnt decrements.
    - Collisions are ignored in HIT and IDLE, and hitSticky is held at 0 in both.
- Leaving IDLE always enters DRIVE; a hit interrupted by enable=0 is not resumed.
- posX and lane are held in IDLE (pause, not reset).
- speedLevel is sampled on the startOfFrame cycle only.

## Timing
- Reset values:
  - posX = INITIAL_X<<FP_SHIFT, so topLeftX=640.
  - lane=0, so topLeftY=160.
  - lfsr=4'b1001, state IDLE, hitCnt=0, hitSticky=0.
  - hitPulse=0, wrapPulse=0, moving=0.
- Latency:
  - All outputs are registered.
  - The new topLeftX/Y, hitPulse, wrapPulse and moving appear the cycle after the startOfFrame cycle.
  - hitPulse and wrapPulse are exactly one cycle wide.
- Coordinates are stable for the whole frame; they never change between startOfFrame pulses.
- If collision and startOfFrame occur in the same cycle, the collision counts toward the frame being closed, so a hit is accepted in that cycle.
- hitPulse and wrapPulse never occur in the same frame.
- Reset asserted mid-frame or mid-HIT returns every register to its reset value immediately (asynchronously).
- Speed 1 arithmetic: 640*64 - 96 = 40864, so topLeftX reads 638 (floor).

## Test plan
- Reset then enable=1, speedLevel=0, 10 frames -> topLeftX 640→630, topLeftY=160, moving=1 from frame 1.
- speedLevel=1, 2 frames from 640 -> topLeftX 638 then 637; speedLevel=3, 1 frame -> 3 px step.
- Drive at speedLevel=3 until below -32:
  - Requirement: 224 frames from 640 reach topLeftX=-32, and frame 225 respawns.
  - Expected: wrapPulse single cycle, topLeftX=640, topLeftY=160+64*lfsr[1:0] per the LFSR model.
- collision held for 3 cycles mid-frame, then 40 frames:
  - one hitPulse, X frozen for 32 frames, moving=0.
  - motion resumes on frame 33.
  - Collisions issued during HIT do not extend it.
- enable=0 during HIT at count 10 -> IDLE with X held. enable=1 -> DRIVE on the next frame.
- collision coincident with startOfFrame -> hitPulse the next cycle; assert reset mid-HIT -> all outputs return to reset values in the same cycle.

Source files
------------

// File: rtl/truck_move.sv
// truck_move: per-frame motion controller for the truck sprite.
// Advances the truck leftward once per video frame at a selectable
// fixed-point speed, respawns it on a pseudo-random lane when it leaves
// the screen, and freezes it for a fixed number of frames after a hit.
module truck_move #(
    parameter int INITIAL_X   = 640,  // respawn / reset X in pixels
    parameter int LANE_BASE_Y = 160,  // Y of lane 0 in pixels
    parameter int LANE_PITCH  = 64,   // Y distance between lanes
    parameter int X_MIN       = -32,  // off-screen threshold in pixels
    parameter int FP_SHIFT    = 6,    // fixed-point fraction bits
    parameter int HIT_FRAMES  = 32    // frames frozen after a hit
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               enable,
    input  logic               collision,
    input  logic [1:0]         speedLevel,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic               hitPulse,
    output logic               wrapPulse,
    output logic               moving
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_HIT   = 2'd2
    } state_t;

    localparam int               FP_ONE     = 1 << FP_SHIFT;
    localparam logic signed [17:0] INIT_FP  = 18'(INITIAL_X * FP_ONE);
    localparam logic signed [17:0] XMIN_FP  = 18'(X_MIN * FP_ONE);
    localparam logic [5:0]       HIT_LOAD   = 6'(HIT_FRAMES - 1);
    localparam logic [3:0]       LFSR_SEED  = 4'b1001;

    state_t              state, state_nxt;
    logic signed [17:0]  pos_x, pos_x_nxt;
    logic signed [17:0]  pos_step;
    logic signed [17:0]  speed;
    logic [1:0]          lane, lane_nxt;
    logic [3:0]          lfsr, lfsr_nxt;
    logic [5:0]          hit_cnt, hit_cnt_nxt;
    logic                hit_sticky, hit_sticky_nxt;
    logic                hit_pulse_nxt;
    logic                wrap_pulse_nxt;

    // Map the speed level onto its per-frame fixed-point displacement.
    always_comb begin
        case (speedLevel)
            2'd0:    speed = 18'(FP_ONE);                 // 1 px
            2'd1:    speed = 18'(FP_ONE + FP_ONE / 2);    // 1.5 px
            2'd2:    speed = 18'(2 * FP_ONE);             // 2 px
            default: speed = 18'(3 * FP_ONE);             // 3 px
        endcase
    end

    // Candidate position if the truck advances this frame.
    assign pos_step = pos_x - speed;

    // Next-state, datapath and pulse decisions; transitions only on frame start.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        state_nxt      = state;
        pos_x_nxt      = pos_x;
        lane_nxt       = lane;
        lfsr_nxt       = lfsr;
        hit_cnt_nxt    = hit_cnt;
        hit_pulse_nxt  = 1'b0;
        wrap_pulse_nxt = 1'b0;

        // Collisions are only remembered while driving.
        if (state != S_DRIVE) begin
            hit_sticky_nxt = 1'b0;
        end else if (collision) begin
            hit_sticky_nxt = 1'b1;
        end else begin
            hit_sticky_nxt = hit_sticky;
        end

        if (startOfFrame) begin
            lfsr_nxt       = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
            // The sticky flag is consumed by this frame's decision below.
            hit_sticky_nxt = 1'b0;

            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state_nxt = S_DRIVE;
                    end
                end

                S_DRIVE: begin
                    if (!enable) begin
                        state_nxt = S_IDLE;
                    end else if (hit_sticky || collision) begin
                        // A collision on this very cycle still belongs to
                        // the frame being closed.
                        state_nxt     = S_HIT;
                        hit_cnt_nxt   = HIT_LOAD;
                        hit_pulse_nxt = 1'b1;
                    end else if (pos_step < XMIN_FP) begin
                        // Lane comes from the LFSR value before this step.
                        pos_x_nxt      = INIT_FP;
                        lane_nxt       = lfsr[1:0];
                        wrap_pulse_nxt = 1'b1;
                    end else begin
                        pos_x_nxt = pos_step;
                    end
                end

                S_HIT: begin
                    if (!enable) begin
                        // An interrupted hit is abandoned, not resumed.
                        state_nxt   = S_IDLE;
                        hit_cnt_nxt = 6'd0;
                    end else if (hit_cnt == 6'd0) begin
                        state_nxt = S_DRIVE;
                    end else begin
                        hit_cnt_nxt = hit_cnt - 6'd1;
                    end
                end

                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs from before the clock edge.
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath and registered output flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_x      <= INIT_FP;
            lane       <= 2'd0;
            lfsr       <= LFSR_SEED;
            hit_cnt    <= 6'd0;
            hit_sticky <= 1'b0;
            hitPulse   <= 1'b0;
            wrapPulse  <= 1'b0;
            moving     <= 1'b0;
        end else begin
            pos_x      <= pos_x_nxt;
            lane       <= lane_nxt;
            lfsr       <= lfsr_nxt;
            hit_cnt    <= hit_cnt_nxt;
            hit_sticky <= hit_sticky_nxt;
            hitPulse   <= hit_pulse_nxt;
            wrapPulse  <= wrap_pulse_nxt;
            moving     <= (state_nxt == S_DRIVE);
        end
    end

    // Pixel coordinates derive directly from registers, so they only
    // change on the cycle after a frame start.
    assign topLeftX = 11'(pos_x >>> FP_SHIFT);
    assign topLeftY = 11'(LANE_BASE_Y + int'(lane) * LANE_PITCH);

endmodule
